// File: rtl/mic_uart_framer.sv
// mic_uart_framer: buffers I2S sample pairs and serialises enabled channels, MSB first, onto a UART byte stream with periodic sync bytes.
module mic_uart_framer #(
  parameter int BYTES_PER_SAMPLE = 2,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int SYNC_PERIOD = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_valid,
  input  logic [31:0] sample_0,
  input  logic [31:0] sample_1,
  input  logic [1:0] chan_en,
  input  logic uart_busy,
  output logic uart_data_valid,
  output logic [7:0] uart_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic overflow,
  output logic [7:0] drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W = 8 * BYTES_PER_SAMPLE;
  localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
  typedef enum logic [2:0] {IDLE, LOAD, SYNC, SEND, GAP, WAIT} state_t;
  state_t state;
  logic [63:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [63:0] head;
  logic [2*W-1:0] frame, sh;
  logic [3:0] nb, left;
  logic [7:0] sync_cnt;
  logic sync_frame, full, req, push, pop;
  assign full = fifo_level == DEPTH;
  assign req = sample_valid && chan_en != 2'b00;
  assign push = req && !full;
  assign pop = state == LOAD;
  assign head = mem[rptr];
  // ch1-only frames put ch1 first; otherwise ch0 leads and ch1 (if any) follows
  assign frame = chan_en == 2'b10 ? {head[63 -: W], head[31 -: W]} : {head[31 -: W], head[63 -: W]};
  assign nb = 4'(BYTES_PER_SAMPLE * (int'(chan_en[0]) + int'(chan_en[1])));
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (push) begin
        mem[wptr] <= {sample_1, sample_0};
        wptr <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      if (req && full) begin
        overflow <= 1'b1;
        drop_count <= drop_count + 8'(drop_count != 8'hFF);
      end
    end
  end
  // emits are registered on entry to SYNC/SEND, so the strobe is visible while in those states
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      uart_data_valid <= 1'b0;
      uart_data <= 8'd0;
      sh <= '0;
      left <= 4'd0;
      sync_cnt <= 8'd0;
      sync_frame <= 1'b0;
    end else begin
      uart_data_valid <= 1'b0;
      case (state)
        IDLE: if (!uart_busy && (fifo_level != '0 || push)) state <= LOAD;
        LOAD: begin
          if (chan_en == 2'b00) state <= IDLE;
          else begin
            sync_frame <= sync_cnt == 8'd0;
            uart_data_valid <= 1'b1;
            uart_data <= sync_cnt == 8'd0 ? SYNC_BYTE : frame[2*W-1 -: 8];
            sh <= sync_cnt == 8'd0 ? frame : frame << 8;
            left <= sync_cnt == 8'd0 ? nb : nb - 4'd1;
            state <= sync_cnt == 8'd0 ? SYNC : SEND;
          end
        end
        SYNC, SEND: state <= GAP;
        GAP: state <= WAIT;
        WAIT: begin
          if (!uart_busy && left != 4'd0) begin
            uart_data_valid <= 1'b1;
            uart_data <= sh[2*W-1 -: 8];
            sh <= sh << 8;
            left <= left - 4'd1;
            state <= SEND;
          end else if (!uart_busy) begin
            sync_cnt <= sync_frame ? 8'(SYNC_PERIOD - 1) : sync_cnt - 8'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
